// File: rtl/canvas_pkg.sv
// rtl/canvas_pkg.sv - canvas geometry, colour constants and FSM state type
package canvas_pkg;
  localparam int CANVAS_W    = 96;
  localparam int CANVAS_H    = 64;
  localparam int CANVAS_NPIX = CANVAS_W * CANVAS_H;

  localparam logic [15:0] WHITE = 16'hFFFF;
  localparam logic [15:0] BLACK = 16'h0000;

  typedef enum logic [1:0] {CLEAR, IDLE, LOCK} state_t;

  // y*96 built from shifts so no multiplier is needed
  function automatic logic [12:0] pix_addr(input logic [6:0] x, input logic [5:0] y);
    return ({7'd0, y} << 6) + ({7'd0, y} << 5) + {6'd0, x};
  endfunction
endpackage

// File: rtl/canvas_ram.sv
// rtl/canvas_ram.sv - 6144x16 simple dual-port frame buffer, read-first
module canvas_ram
  import canvas_pkg::*;
(
  input  logic        clk,
  input  logic        we,
  input  logic [12:0] waddr,
  input  logic [15:0] wdata,
  input  logic [12:0] raddr,
  output logic [15:0] rdata
);
  logic [15:0] mem [0:CANVAS_NPIX-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/paint_canvas.sv
// rtl/paint_canvas.sv - cursor-driven paint board with clear sequencer and overlay readout
module paint_canvas
  import canvas_pkg::*;
#(
  parameter int          HOLDOFF    = 24_999_999,
  parameter logic [15:0] CLR_COLOUR = 16'hFFFF
) (
  input  logic        CLOCK,
  input  logic        RESET_N,
  input  logic [12:0] pixel_index,
  input  logic [15:0] selected_colour,
  input  logic        btnU,
  input  logic        btnD,
  input  logic        btnL,
  input  logic        btnR,
  input  logic        btnC,
  input  logic        sw12,
  input  logic        sw13,
  input  logic        sw15,
  output logic [15:0] curr_pixel_oled,
  output logic [6:0]  cursor_x,
  output logic [5:0]  cursor_y,
  output logic        busy
);
  localparam logic [31:0] HOLD      = 32'(HOLDOFF);
  localparam logic [12:0] LAST_ADDR = 13'(CANVAS_NPIX - 1);
  localparam logic [6:0]  MAX_X     = 7'(CANVAS_W - 1);
  localparam logic [5:0]  MAX_Y     = 6'(CANVAS_H - 1);

  state_t      state, next_state;
  logic [12:0] clr_addr;
  logic [31:0] lock_cnt;
  logic [4:0]  btn_s1, btn_s2;   // {C, U, D, L, R}
  logic        sw15_q;
  logic        clr_rise;
  logic        mv_u, mv_d, mv_l, mv_r;
  logic        we;
  logic [12:0] waddr, cursor_addr, idx_q;
  logic [15:0] wdata, ram_q;

  assign cursor_addr = pix_addr(cursor_x, cursor_y);
  assign clr_rise    = sw15 & ~sw15_q;
  assign busy        = (state == CLEAR);

  always_comb begin
    next_state = state;
    we         = 1'b0;
    waddr      = cursor_addr;
    wdata      = selected_colour;
    mv_u       = 1'b0;
    mv_d       = 1'b0;
    mv_l       = 1'b0;
    mv_r       = 1'b0;
    case (state)
      CLEAR: begin
        we    = 1'b1;
        waddr = clr_addr;
        wdata = CLR_COLOUR;
        if (clr_addr == LAST_ADDR) next_state = IDLE;
      end
      IDLE: begin
        // clear request outranks any button; L/R vanish entirely in palette mode
        if (clr_rise)                next_state = CLEAR;
        else if (btn_s2[4])          begin next_state = LOCK; we   = sw12; end
        else if (btn_s2[3])          begin next_state = LOCK; mv_u = 1'b1; end
        else if (btn_s2[2])          begin next_state = LOCK; mv_d = 1'b1; end
        else if (btn_s2[1] && !sw13) begin next_state = LOCK; mv_l = 1'b1; end
        else if (btn_s2[0] && !sw13) begin next_state = LOCK; mv_r = 1'b1; end
      end
      LOCK: begin
        if (clr_rise)              next_state = CLEAR;
        else if (lock_cnt == HOLD) next_state = IDLE;
      end
      default: next_state = CLEAR;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= CLEAR;
      clr_addr <= 13'd0;
      lock_cnt <= 32'd0;
      btn_s1   <= 5'd0;
      btn_s2   <= 5'd0;
      sw15_q   <= 1'b0;
      cursor_x <= 7'd0;
      cursor_y <= 6'd0;
    end else begin
      state    <= next_state;
      btn_s1   <= {btnC, btnU, btnD, btnL, btnR};
      btn_s2   <= btn_s1;
      sw15_q   <= sw15;
      clr_addr <= (state == CLEAR && next_state == CLEAR) ? clr_addr + 13'd1 : 13'd0;
      lock_cnt <= (state == LOCK && next_state == LOCK) ? lock_cnt + 32'd1 : 32'd0;
      if (mv_u && cursor_y != 6'd0)  cursor_y <= cursor_y - 6'd1;
      if (mv_d && cursor_y != MAX_Y) cursor_y <= cursor_y + 6'd1;
      if (mv_l && cursor_x != 7'd0)  cursor_x <= cursor_x - 7'd1;
      if (mv_r && cursor_x != MAX_X) cursor_x <= cursor_x + 7'd1;
    end
  end

  canvas_ram u_ram (
    .clk   (CLOCK),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (pixel_index),
    .rdata (ram_q)
  );

  // ram_q is stage 1; stage 2 inverts the pixel under the cursor
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      idx_q           <= 13'd0;
      curr_pixel_oled <= BLACK;
    end else begin
      idx_q           <= pixel_index;
      curr_pixel_oled <= (sw12 && idx_q == cursor_addr) ? ~ram_q : ram_q;
    end
  end
endmodule

// File: tb/tb_paint_canvas.sv
// tb/tb_paint_canvas.sv - self-checking bench for paint_canvas
module tb_paint_canvas;
  localparam int HOLD = 4;

  logic        CLOCK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [12:0] pixel_index = 13'd0;
  logic [15:0] selected_colour = 16'd0;
  logic        btnU = 0, btnD = 0, btnL = 0, btnR = 0, btnC = 0;
  logic        sw12 = 0, sw13 = 0, sw15 = 0;
  logic [15:0] curr_pixel_oled;
  logic [6:0]  cursor_x;
  logic [5:0]  cursor_y;
  logic        busy;

  always #5 CLOCK = ~CLOCK;

  paint_canvas #(.HOLDOFF(HOLD), .CLR_COLOUR(16'hFFFF)) dut (
    .CLOCK           (CLOCK),
    .RESET_N         (RESET_N),
    .pixel_index     (pixel_index),
    .selected_colour (selected_colour),
    .btnU            (btnU),
    .btnD            (btnD),
    .btnL            (btnL),
    .btnR            (btnR),
    .btnC            (btnC),
    .sw12            (sw12),
    .sw13            (sw13),
    .sw15            (sw15),
    .curr_pixel_oled (curr_pixel_oled),
    .cursor_x        (cursor_x),
    .cursor_y        (cursor_y),
    .busy            (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] model_mem [0:6143];
  int mx = 0, my = 0;
  int painted[$];

  typedef struct {
    int          btn;   // 0=C 1=U 2=D 3=L 4=R
    logic        s12;
    logic        s13;
    logic [15:0] col;
    int          ex;
    int          ey;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLOCK);
      #1;
    end
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: btnC = v;
      1: btnU = v;
      2: btnD = v;
      3: btnL = v;
      default: btnR = v;
    endcase
  endtask

  task automatic model_press(input int b);
    case (b)
      0: if (sw12) begin model_mem[my*96+mx] = selected_colour; painted.push_back(my*96+mx); end
      1: if (my > 0) my--;
      2: if (my < 63) my++;
      3: if (!sw13 && mx > 0) mx--;
      default: if (!sw13 && mx < 95) mx++;
    endcase
  endtask

  task automatic press(input int b);
    set_btn(b, 1'b1);
    tick();
    set_btn(b, 1'b0);
    tick(HOLD + 8);
    model_press(b);
  endtask

  function automatic logic [15:0] exp_pix(input int idx);
    return (sw12 && idx == my*96+mx) ? ~model_mem[idx] : model_mem[idx];
  endfunction

  task automatic read_pix(input int idx, output logic [15:0] val);
    pixel_index = 13'(idx);
    tick(2);
    val = curr_pixel_oled;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] v;
    int changes[$];
    int prev_y;

    for (int i = 0; i < 6144; i++) model_mem[i] = 16'hFFFF;

    #23;
    check("reset_pixel", 32'(curr_pixel_oled), 32'h0000);
    check("reset_x", 32'(cursor_x), 0);
    check("reset_y", 32'(cursor_y), 0);
    check("reset_busy", 32'(busy), 1);

    @(negedge CLOCK);
    RESET_N = 1'b1;
    tick(6143);
    check("busy_last_clear_cycle", 32'(busy), 1);
    tick();
    check("busy_after_clear", 32'(busy), 0);

    for (int i = 0; i < 6144; i++) begin
      read_pix(i, v);
      check("scan_white", 32'(v), 32'hFFFF);
    end

    vecs[0] = '{2, 1'b1, 1'b0, 16'hF800, 0, 1};
    vecs[1] = '{2, 1'b1, 1'b0, 16'hF800, 0, 2};
    vecs[2] = '{4, 1'b1, 1'b0, 16'hF800, 1, 2};
    vecs[3] = '{4, 1'b1, 1'b0, 16'hF800, 2, 2};
    vecs[4] = '{4, 1'b1, 1'b0, 16'hF800, 3, 2};
    vecs[5] = '{0, 1'b1, 1'b0, 16'hF800, 3, 2};
    vecs[6] = '{3, 1'b1, 1'b1, 16'h1234, 3, 2};
    vecs[7] = '{4, 1'b1, 1'b1, 16'h1234, 3, 2};
    for (int i = 0; i < 8; i++) begin
      sw12 = vecs[i].s12;
      sw13 = vecs[i].s13;
      selected_colour = vecs[i].col;
      press(vecs[i].btn);
      check($sformatf("vec%0d_x", i), 32'(cursor_x), 32'(vecs[i].ex));
      check($sformatf("vec%0d_y", i), 32'(cursor_y), 32'(vecs[i].ey));
    end
    sw12 = 1'b1;
    read_pix(195, v);
    check("pix195_overlay", 32'(v), 32'h07FF);
    sw12 = 1'b0;
    read_pix(195, v);
    check("pix195_plain", 32'(v), 32'hF800);

    // palette mode: L is ignored without lockout, so U one cycle later lands
    sw13 = 1'b1;
    btnL = 1'b1; tick();
    btnL = 1'b0; btnU = 1'b1; tick();
    btnU = 1'b0; tick(HOLD + 8);
    my--;
    check("sw13_nolock_x", 32'(cursor_x), 32'(mx));
    check("sw13_nolock_y", 32'(cursor_y), 1);
    sw13 = 1'b0;

    press(1); press(3); press(3); press(3);
    // saturated U still locks, so a D one cycle later is dropped
    btnU = 1'b1; tick();
    btnU = 1'b0; btnD = 1'b1; tick();
    btnD = 1'b0; tick(HOLD + 8);
    press(3);
    check("sat_low_x", 32'(cursor_x), 0);
    check("sat_low_y", 32'(cursor_y), 0);

    for (int i = 0; i < 95; i++) press(4);
    for (int i = 0; i < 63; i++) press(2);
    press(2); press(4);
    check("sat_high_x", 32'(cursor_x), 95);
    check("sat_high_y", 32'(cursor_y), 63);

    // hold U: first effect 3 cycles after press, then every HOLD+2
    prev_y = int'(cursor_y);
    btnU = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (int'(cursor_y) != prev_y) changes.push_back(c);
      prev_y = int'(cursor_y);
    end
    btnU = 1'b0;
    check("hold_count", 32'(changes.size()), 3);
    for (int j = 0; j < changes.size(); j++)
      check($sformatf("hold_step%0d", j), 32'(changes[j]), 32'(3 + j*(HOLD+2)));
    // synchronised level is visible to the FSM through edge 22
    for (int k = 3; k <= 22; k += HOLD + 2) if (my > 0) my--;
    tick(HOLD + 10);
    check("hold_total_y", 32'(cursor_y), 32'(my));

    // paint, then request clear while locked
    sw12 = 1'b1;
    selected_colour = 16'h001F;
    btnC = 1'b1; tick();
    btnC = 1'b0; tick(3);
    sw15 = 1'b1; tick();
    check("clear_busy_rise", 32'(busy), 1);
    for (int c = 1; c <= 6144; c++) begin
      if (c == 1)    sw15 = 1'b0;
      if (c == 100)  btnU = 1'b1;
      if (c == 101)  btnU = 1'b0;
      if (c == 3000) sw15 = 1'b1;
      if (c == 3001) sw15 = 1'b0;
      tick();
      if (c == 6143) check("clear_busy_hold", 32'(busy), 1);
      if (c == 6144) check("clear_busy_fall", 32'(busy), 0);
    end
    for (int i = 0; i < 6144; i++) model_mem[i] = 16'hFFFF;
    painted.delete();
    check("clear_keep_x", 32'(cursor_x), 32'(mx));
    check("clear_keep_y", 32'(cursor_y), 32'(my));
    sw12 = 1'b0;
    read_pix(my*96+mx, v);
    check("clear_painted_white", 32'(v), 32'hFFFF);

    for (int i = 0; i < 40; i++) begin
      sw12 = 1'($urandom_range(0, 1));
      sw13 = 1'($urandom_range(0, 1));
      selected_colour = 16'($urandom);
      press(int'($urandom_range(0, 4)));
      check($sformatf("rnd%0d_x", i), 32'(cursor_x), 32'(mx));
      check($sformatf("rnd%0d_y", i), 32'(cursor_y), 32'(my));
    end
    painted.push_back(my*96+mx);
    painted.push_back(0);
    painted.push_back(6143);
    foreach (painted[i]) begin
      sw12 = 1'($urandom_range(0, 1));
      read_pix(painted[i], v);
      check($sformatf("rnd_pix%0d", painted[i]), 32'(v), 32'(exp_pix(painted[i])));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
